// File: rtl/order_payload_pkg.sv
// Shared constants for the order payload framer: header layout and beat-count helper.
package order_payload_pkg;

    localparam int HDR_BYTES     = 12;
    localparam int HDR_SID_OFF   = 0;
    localparam int HDR_SEQ_OFF   = 2;
    localparam int HDR_EPOCH_OFF = 6;
    localparam int HDR_MS_OFF    = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic int nbeats(input int msg_bytes, input int data_w);
        return (msg_bytes * 8 + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts one past the last winner.
// Pointer moves only when the caller strobes adv with at least one request present.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_nxt;
    logic          found;
    int            idx;

    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (adv && found) begin
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/order_payload_mux.sv
// Order payload framer: latches PE records, picks one round-robin, streams header+record as AXI4-Stream.
// First beat 2 cycles after pe_enable; beats held while tready is low, next message follows the last beat with no bubble.
module order_payload_mux
    import order_payload_pkg::*;
#(
    parameter int NUM_CH    = 10,
    parameter int REC_BYTES = 39,
    parameter int DATA_W    = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   session_id,
    input  logic [31:0]                   epoch_s,
    input  logic [15:0]                   ms,
    input  logic [31:0]                   seq_init,
    input  logic                          seq_load,
    input  logic [NUM_CH-1:0]             pe_enable,
    input  logic [NUM_CH*REC_BYTES*8-1:0] pe_rec,
    output logic [NUM_CH-1:0]             pe_ack,
    output logic [NUM_CH-1:0]             pe_busy,
    output logic [NUM_CH-1:0]             pe_drop,
    input  logic                          tready,
    output logic                          tvalid,
    output logic [DATA_W-1:0]             tdata,
    output logic [DATA_W/8-1:0]           tkeep,
    output logic [DATA_W/8-1:0]           tstrb,
    output logic                          tlast
);

    localparam int REC_W      = REC_BYTES * 8;
    localparam int MSG_BYTES  = HDR_BYTES + REC_BYTES;
    localparam int BPB        = DATA_W / 8;
    localparam int NBEATS     = nbeats(MSG_BYTES, DATA_W);
    localparam int BW         = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LAST_BYTES = MSG_BYTES - (NBEATS - 1) * BPB;
    localparam logic [BPB-1:0] KEEP_ALL  = '1;
    localparam logic [BPB-1:0] KEEP_LAST = KEEP_ALL >> (BPB - LAST_BYTES);

    state_t                     state_q, state_nxt;
    logic [BW-1:0]              beat_q, beat_nxt;
    logic [NUM_CH-1:0]          pending_q, pending_nxt;
    logic [NUM_CH-1:0]          cap;
    logic [NUM_CH-1:0]          drop_nxt;
    logic [NUM_CH-1:0]          arb_gnt;
    logic [NUM_CH-1:0]          cur_ch_q;
    logic [NUM_CH-1:0]          ack_q, drop_q;
    logic [REC_W-1:0]           rec_q [NUM_CH];
    logic [REC_W-1:0]           rec_sel;
    logic [NBEATS*DATA_W-1:0]   msg_q, msg_nxt;
    logic [31:0]                seq_cur, seq_msg;
    logic                       want, grant, hs, last_beat;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (pending_q),
        .adv   (grant),
        .gnt   (arb_gnt)
    );

    assign tvalid    = (state_q == ST_SEND);
    assign hs        = tvalid && tready;
    assign last_beat = (beat_q == BW'(NBEATS - 1));
    assign tlast     = tvalid && last_beat;
    assign tdata     = tvalid ? msg_q[int'(beat_q) * DATA_W +: DATA_W] : '0;
    assign tkeep     = !tvalid ? '0 : (last_beat ? KEEP_LAST : KEEP_ALL);
    assign tstrb     = tkeep;
    assign pe_ack    = ack_q;
    assign pe_drop   = drop_q;
    assign pe_busy   = pending_q | (tvalid ? cur_ch_q : '0);

    // seq_load overrides the running counter, even on a grant cycle
    assign seq_msg   = seq_load ? seq_init : seq_cur;

    always_comb begin
        state_nxt = state_q;
        beat_nxt  = beat_q;
        want      = 1'b0;
        case (state_q)
            ST_IDLE: want = 1'b1;
            ST_SEND: begin
                if (hs) begin
                    if (last_beat) want = 1'b1;
                    else           beat_nxt = beat_q + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        grant = want && (|pending_q);
        if (grant) begin
            state_nxt = ST_SEND;
            beat_nxt  = '0;
        end else if (state_q == ST_SEND && hs && last_beat) begin
            state_nxt = ST_IDLE;
        end
    end

    // A channel being granted this cycle may accept a new record: the grant takes the old one
    always_comb begin
        pending_nxt = pending_q;
        cap         = '0;
        drop_nxt    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant && arb_gnt[i]) pending_nxt[i] = 1'b0;
            if (pe_enable[i]) begin
                if (!pending_q[i] || (grant && arb_gnt[i])) begin
                    cap[i]         = 1'b1;
                    pending_nxt[i] = 1'b1;
                end else begin
                    drop_nxt[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rec_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_gnt[i]) rec_sel = rec_q[i];
        end
    end

    always_comb begin
        msg_nxt = '0;
        for (int b = 0; b < 2; b++) begin
            msg_nxt[8*(HDR_SID_OFF + b) +: 8] = session_id[8*(1 - b) +: 8];
            msg_nxt[8*(HDR_MS_OFF + b)  +: 8] = ms[8*(1 - b) +: 8];
        end
        for (int b = 0; b < 4; b++) begin
            msg_nxt[8*(HDR_SEQ_OFF + b)   +: 8] = seq_msg[8*(3 - b) +: 8];
            msg_nxt[8*(HDR_EPOCH_OFF + b) +: 8] = epoch_s[8*(3 - b) +: 8];
        end
        for (int j = 0; j < REC_BYTES; j++) begin
            msg_nxt[8*(HDR_BYTES + j) +: 8] = rec_sel[8*(REC_BYTES - 1 - j) +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            pending_q <= '0;
            msg_q     <= '0;
            cur_ch_q  <= '0;
            ack_q     <= '0;
            drop_q    <= '0;
            seq_cur   <= '0;
        end else begin
            state_q   <= state_nxt;
            beat_q    <= beat_nxt;
            pending_q <= pending_nxt;
            ack_q     <= grant ? arb_gnt : '0;
            drop_q    <= drop_nxt;
            if (grant) begin
                msg_q    <= msg_nxt;
                cur_ch_q <= arb_gnt;
                seq_cur  <= seq_msg + 32'd1;
            end else if (seq_load) begin
                seq_cur  <= seq_init;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (cap[i]) rec_q[i] <= pe_rec[i*REC_W +: REC_W];
        end
    end

endmodule

// File: tb/tb_order_payload_mux.sv
// Scoreboard bench for order_payload_mux: expected beats queued at stimulus time, compared at each handshake.
module tb_order_payload_mux;

    localparam int NUM_CH    = 10;
    localparam int REC_BYTES = 39;
    localparam int DATA_W    = 256;
    localparam int REC_W     = REC_BYTES * 8;
    localparam int MSG_BYTES = 12 + REC_BYTES;
    localparam int BPB       = DATA_W / 8;
    localparam int NBEATS    = (MSG_BYTES + BPB - 1) / BPB;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [BPB-1:0]    k;
        logic              l;
    } beat_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [15:0]               sid;
    logic [31:0]               ep;
    logic [15:0]               ms_v;
    logic [31:0]               seq_init;
    logic                      seq_load;
    logic [NUM_CH-1:0]         pe_enable;
    logic [NUM_CH*REC_W-1:0]   pe_rec;
    logic [NUM_CH-1:0]         pe_ack, pe_busy, pe_drop;
    logic                      tready, tvalid, tlast;
    logic [DATA_W-1:0]         tdata;
    logic [BPB-1:0]            tkeep, tstrb;

    beat_t          sb[$];
    logic [REC_W-1:0] recs [NUM_CH];
    logic [31:0]    exp_seq;
    int             n_chk = 0;
    int             n_err = 0;
    int             gap_cnt = 0;
    logic           in_burst = 1'b0;
    int             ack_cnt [NUM_CH];
    int             drop_cnt [NUM_CH];

    always #5 clk = ~clk;

    order_payload_mux #(.NUM_CH(NUM_CH), .REC_BYTES(REC_BYTES), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .session_id (sid),
        .epoch_s    (ep),
        .ms         (ms_v),
        .seq_init   (seq_init),
        .seq_load   (seq_load),
        .pe_enable  (pe_enable),
        .pe_rec     (pe_rec),
        .pe_ack     (pe_ack),
        .pe_busy    (pe_busy),
        .pe_drop    (pe_drop),
        .tready     (tready),
        .tvalid     (tvalid),
        .tdata      (tdata),
        .tkeep      (tkeep),
        .tstrb      (tstrb),
        .tlast      (tlast)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (tvalid) begin
                in_burst = 1'b1;
                if (tready) begin
                    if (sb.size() == 0) begin
                        check("sb_size_at_beat", sb.size(), 1);
                    end else begin
                        beat_t e;
                        e = sb.pop_front();
                        check("tdata", tdata, e.d);
                        check("tkeep", tkeep, e.k);
                        check("tstrb", tstrb, e.k);
                        check("tlast", tlast, e.l);
                    end
                end
            end else if (in_burst && sb.size() != 0) begin
                gap_cnt++;
            end
            if (sb.size() == 0) in_burst = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (pe_ack[i])  ack_cnt[i]++;
                if (pe_drop[i]) drop_cnt[i]++;
            end
        end
    end

    task automatic set_rec(input int ch);
        logic [319:0] t;
        for (int w = 0; w < 10; w++) t[32*w +: 32] = $urandom;
        recs[ch] = t[REC_W-1:0];
        pe_rec[ch*REC_W +: REC_W] = recs[ch];
    endtask

    task automatic push_exp(input int ch);
        logic [7:0] m [MSG_BYTES];
        beat_t bt;
        m[0]  = sid[15:8];      m[1]  = sid[7:0];
        m[2]  = exp_seq[31:24]; m[3]  = exp_seq[23:16];
        m[4]  = exp_seq[15:8];  m[5]  = exp_seq[7:0];
        m[6]  = ep[31:24];      m[7]  = ep[23:16];
        m[8]  = ep[15:8];       m[9]  = ep[7:0];
        m[10] = ms_v[15:8];     m[11] = ms_v[7:0];
        for (int j = 0; j < REC_BYTES; j++) m[12 + j] = recs[ch][8*(REC_BYTES - 1 - j) +: 8];
        for (int b = 0; b < NBEATS; b++) begin
            bt.d = '0;
            bt.k = '0;
            for (int lane = 0; lane < BPB; lane++) begin
                if (b * BPB + lane < MSG_BYTES) begin
                    bt.d[8*lane +: 8] = m[b * BPB + lane];
                    bt.k[lane] = 1'b1;
                end
            end
            bt.l = (b == NBEATS - 1);
            sb.push_back(bt);
        end
        exp_seq = exp_seq + 32'd1;
    endtask

    task automatic step(input logic [NUM_CH-1:0] en);
        pe_enable = en;
        @(posedge clk);
        #1;
        pe_enable = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || tvalid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NUM_CH; i++) begin
            ack_cnt[i]  = 0;
            drop_cnt[i] = 0;
        end
        gap_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sid = 16'h00df; ep = 32'h5e4c9098; ms_v = 16'h0096;
        seq_init = '0; seq_load = 1'b0; pe_enable = '0; pe_rec = '0; tready = 1'b1;
        clear_counts();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tkeep", tkeep, 0);
        check("rst_tstrb", tstrb, 0);
        check("rst_ack", pe_ack, 0);
        check("rst_drop", pe_drop, 0);
        check("rst_busy", pe_busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // single channel 1, loaded sequence, latency and follow-on sequence
        seq_init = 32'h00000b23; seq_load = 1'b1;
        @(posedge clk); #1;
        seq_load = 1'b0;
        exp_seq = 32'h00000b23;
        set_rec(1); push_exp(1);
        step(10'b0000000010);
        @(negedge clk);
        check("lat_e0_tvalid", tvalid, 0);
        check("lat_e0_busy1", pe_busy[1], 1);
        @(negedge clk);
        check("lat_e1_tvalid", tvalid, 1);
        check("lat_e1_ack", pe_ack, 10'b0000000010);
        wait_drain();
        check("t1_ack1", ack_cnt[1], 1);
        set_rec(1); push_exp(1);
        step(10'b0000000010);
        wait_drain();
        check("t1_ack1_again", ack_cnt[1], 2);
        check("t1_gaps", gap_cnt, 0);

        // three channels at once after reset: order 0,2,5 back to back
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        clear_counts();
        exp_seq = 32'h0;
        set_rec(0); set_rec(2); set_rec(5);
        push_exp(0); push_exp(2); push_exp(5);
        step(10'b0000100101);
        wait_drain();
        check("t2_gaps", gap_cnt, 0);
        check("t2_ack0", ack_cnt[0], 1);
        check("t2_ack5", ack_cnt[5], 1);

        // backpressure toggling; pointer sits at 6 so channel 7 precedes 4
        clear_counts();
        set_rec(4); set_rec(7);
        push_exp(7); push_exp(4);
        step(10'b0010010000);
        repeat (16) begin
            tready = ~tready;
            @(posedge clk); #1;
        end
        tready = 1'b1;
        wait_drain();
        check("t3_gaps", gap_cnt, 0);

        // re-enable while pending is dropped; re-enable in the grant cycle is kept
        clear_counts();
        set_rec(3); set_rec(8);
        push_exp(8); push_exp(3);
        step(10'b0100001000);
        pe_rec[3*REC_W +: REC_W] = ~recs[3];
        step(10'b0000001000);
        step(10'b0000000000);
        set_rec(3); push_exp(3);
        step(10'b0000001000);
        wait_drain();
        check("t4_drop3", drop_cnt[3], 1);
        check("t4_ack3", ack_cnt[3], 2);
        check("t4_ack8", ack_cnt[8], 1);
        check("t4_gaps", gap_cnt, 0);

        // sequence load coincident with grant, then wrap to zero
        clear_counts();
        sid = 16'h1234; ep = 32'hcafef00d; ms_v = 16'h03e7;
        exp_seq = 32'hffffffff;
        set_rec(6); set_rec(9);
        push_exp(6); push_exp(9);
        step(10'b1001000000);
        seq_init = 32'hffffffff; seq_load = 1'b1;
        step(10'b0000000000);
        seq_load = 1'b0;
        wait_drain();
        check("t5_gaps", gap_cnt, 0);

        // reset on beat 0 with another channel pending
        tready = 1'b0;
        step(10'b0000000110);
        step(10'b0000000000);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_tvalid", tvalid, 0);
        check("t6_busy", pe_busy, 0);
        check("t6_ack", pe_ack, 0);
        tready = 1'b1;
        clear_counts();
        exp_seq = 32'h0;
        set_rec(0); set_rec(9);
        push_exp(0); push_exp(9);
        @(posedge clk); #1;
        step(10'b1000000001);
        wait_drain();
        check("t6_ack0", ack_cnt[0], 1);
        check("t6_ack2", ack_cnt[2], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
